// File: rtl/swipt_pkg.sv
// Shared definitions for the SWIPT amplitude-link receiver: rx state encoding,
// frame constants and the parity helper used when SWIPT_RX_PARITY_EN is defined.
package swipt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CALIB  = 3'd1,
    ST_HUNT   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } rx_state_t;

  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

  // Even parity: the parity bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/swipt_window_avg.sv
// Clear/accumulate/shift averager shared by idle calibration and per-bit windows.
// The mean output already includes the current sample, so a decision can be
// taken on the last sample cycle of a window without an extra pipeline stage.
module swipt_window_avg #(
  parameter int ADC_W    = 12,
  parameter int AVG_LOG2 = 8,
  parameter int CAL_LOG2 = 12
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             cal_i,
  input  logic [ADC_W-1:0] sample_i,
  output logic [ADC_W-1:0] mean_o
);

  localparam int ACC_W = ADC_W + CAL_LOG2;

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] base_s;
  logic [ACC_W-1:0] add_s;
  logic [ACC_W-1:0] sum_s;

  // Running sum: clear restarts from the current sample, enable adds it.
  always_comb begin
    base_s = '0;
    add_s  = '0;
    if (clr_i) begin
      base_s = '0;
    end else begin
      base_s = acc_q;
    end
    if (en_i) begin
      add_s = {{CAL_LOG2{1'b0}}, sample_i};
    end else begin
      add_s = '0;
    end
    sum_s = base_s + add_s;
    acc_d = sum_s;
    if (cal_i) begin
      mean_o = sum_s[CAL_LOG2 +: ADC_W];
    end else begin
      mean_o = sum_s[AVG_LOG2 +: ADC_W];
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/swipt_ask_receiver.sv
// Receive-side demodulator for the SWIPT duty-cycle data link.
// Calibrates an idle threshold from the DC-current ADC channel, then decodes
// frames (start '1', 8 data bits LSB first, stop '0') by averaging a window in
// the middle of each bit. Decoded bytes leave on a valid/ready port.
// Optional build macro: SWIPT_RX_PARITY_EN adds an even-parity bit before stop.
module swipt_ask_receiver
  import swipt_pkg::*;
#(
  parameter int               ADC_W      = 12,
  parameter int               BIT_CYCLES = 25000,
  parameter int               AVG_LOG2   = 8,
  parameter int               CAL_LOG2   = 12,
  parameter logic [ADC_W-1:0] HYST       = 12'd64,
  parameter logic [6:0]       ADC_ADDR   = 7'h1E
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             enable,
  input  logic [ADC_W-1:0] ADC_in,
  output logic [6:0]       adc_address,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_busy,
  output logic [ADC_W-1:0] threshold,
  output logic             frame_err,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CNT_BC = $clog2(BIT_CYCLES);
  localparam int CNT_W  = (CNT_BC > CAL_LOG2) ? CNT_BC : CAL_LOG2;
  localparam int WIN_START = BIT_CYCLES / 2 - (2 ** (AVG_LOG2 - 1));
  localparam int WIN_LAST  = WIN_START + (2 ** AVG_LOG2) - 1;

  localparam logic [CNT_W-1:0] WIN_START_C = CNT_W'(WIN_START);
  localparam logic [CNT_W-1:0] WIN_LAST_C  = CNT_W'(WIN_LAST);
  localparam logic [CNT_W-1:0] BIT_LAST_C  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CAL_LAST_C  = CNT_W'((2 ** CAL_LOG2) - 1);
  localparam logic [CNT_W-1:0] CNT_ONE_C   = CNT_W'(1);

  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_pos_q, bit_pos_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [ADC_W-1:0] thr_q, thr_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_busy_q, rx_busy_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             parity_err_q, parity_err_d;
`ifdef SWIPT_RX_PARITY_EN
  logic             par_bit_q, par_bit_d;
`endif

  logic             in_bit_s;
  logic             in_win_s;
  logic             dec_cyc_s;
  logic             bit_end_s;
  logic             bit_val_s;
  logic             avg_clr_s;
  logic             avg_en_s;
  logic             avg_cal_s;
  logic [ADC_W-1:0] avg_mean_s;
  logic [ADC_W:0]   thr_sum_s;

  swipt_window_avg #(
    .ADC_W    (ADC_W),
    .AVG_LOG2 (AVG_LOG2),
    .CAL_LOG2 (CAL_LOG2)
  ) u_avg (
    .clk      (clk),
    .nrst     (nrst),
    .clr_i    (avg_clr_s),
    .en_i     (avg_en_s),
    .cal_i    (avg_cal_s),
    .sample_i (ADC_in),
    .mean_o   (avg_mean_s)
  );

  // Bit-timing qualifiers and averager control.
  always_comb begin
    in_bit_s  = (state_q == ST_START) || (state_q == ST_DATA) ||
                (state_q == ST_PARITY) || (state_q == ST_STOP);
    in_win_s  = (cnt_q >= WIN_START_C) && (cnt_q <= WIN_LAST_C);
    dec_cyc_s = (cnt_q == WIN_LAST_C);
    bit_end_s = (cnt_q == BIT_LAST_C);
    bit_val_s = (avg_mean_s > thr_q);
    avg_cal_s = (state_q == ST_CALIB);
    avg_clr_s = ((state_q == ST_CALIB) && (cnt_q == '0)) ||
                (in_bit_s && (cnt_q == WIN_START_C));
    avg_en_s  = (state_q == ST_CALIB) || (in_bit_s && in_win_s);
    thr_sum_s = {1'b0, avg_mean_s} + {1'b0, HYST};
  end

  // Next-state and datapath logic for the receive FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_pos_d    = bit_pos_q;
    shreg_d      = shreg_q;
    thr_d        = thr_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
    parity_err_d = 1'b0;
`ifdef SWIPT_RX_PARITY_EN
    par_bit_d    = par_bit_q;
`endif

    // Sink handshake: an accepted byte is released next cycle.
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end

    if (!enable && (state_q != ST_IDLE)) begin
      // Link dropped: abandon any partial frame, keep the delivered byte.
      state_d   = ST_IDLE;
      cnt_d     = '0;
      bit_pos_d = 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d     = '0;
          bit_pos_d = 4'd0;
          if (enable) begin
            state_d = ST_CALIB;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CALIB: begin
          if (cnt_q == CAL_LAST_C) begin
            if (thr_sum_s[ADC_W]) begin
              thr_d = {ADC_W{1'b1}};
            end else begin
              thr_d = thr_sum_s[ADC_W-1:0];
            end
            cnt_d   = '0;
            state_d = ST_HUNT;
          end else begin
            cnt_d = cnt_q + CNT_ONE_C;
          end
        end
        ST_HUNT: begin
          // The detecting cycle itself counts as cycle 0 of the start bit.
          if (ADC_in > thr_q) begin
            cnt_d     = CNT_ONE_C;
            bit_pos_d = 4'd0;
            state_d   = ST_START;
          end else begin
            cnt_d = '0;
          end
        end
        ST_START: begin
          if (bit_end_s) begin
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE_C;
          end
          if (dec_cyc_s && (bit_val_s != START_BIT)) begin
            cnt_d   = '0;
            state_d = ST_HUNT;
          end else if (bit_end_s) begin
            bit_pos_d = 4'd0;
            state_d   = ST_DATA;
          end else begin
            state_d = ST_START;
          end
        end
        ST_DATA: begin
          if (bit_end_s) begin
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE_C;
          end
          if (dec_cyc_s) begin
            shreg_d   = {bit_val_s, shreg_q[7:1]};
            bit_pos_d = bit_pos_q + 4'd1;
          end else begin
            shreg_d = shreg_q;
          end
          if (bit_end_s && (bit_pos_q == 4'(DATA_BITS))) begin
            bit_pos_d = 4'd0;
`ifdef SWIPT_RX_PARITY_EN
            state_d   = ST_PARITY;
`else
            state_d   = ST_STOP;
`endif
          end else begin
            state_d = ST_DATA;
          end
        end
`ifdef SWIPT_RX_PARITY_EN
        ST_PARITY: begin
          if (bit_end_s) begin
            cnt_d   = '0;
            state_d = ST_STOP;
          end else begin
            cnt_d = cnt_q + CNT_ONE_C;
          end
          if (dec_cyc_s) begin
            par_bit_d = bit_val_s;
          end else begin
            par_bit_d = par_bit_q;
          end
        end
`endif
        ST_STOP: begin
          if (dec_cyc_s) begin
            // Re-hunt immediately; the rest of the stop bit is idle level.
            cnt_d   = '0;
            state_d = ST_HUNT;
            if (bit_val_s != STOP_BIT) begin
              frame_err_d = 1'b1;
`ifdef SWIPT_RX_PARITY_EN
            end else if (par_bit_q != even_parity(shreg_q)) begin
              parity_err_d = 1'b1;
`endif
            end else if (!rx_valid_q || rx_ready) begin
              rx_data_d  = shreg_q;
              rx_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE_C;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      endcase
    end

    rx_busy_d = (state_d == ST_START) || (state_d == ST_DATA) ||
                (state_d == ST_PARITY) || (state_d == ST_STOP);
  end

  // FSM, counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_pos_q    <= 4'd0;
      shreg_q      <= 8'd0;
      thr_q        <= {ADC_W{1'b1}};
      rx_data_q    <= 8'd0;
      rx_valid_q   <= 1'b0;
      rx_busy_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
`ifdef SWIPT_RX_PARITY_EN
      par_bit_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_pos_q    <= bit_pos_d;
      shreg_q      <= shreg_d;
      thr_q        <= thr_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_busy_q    <= rx_busy_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      parity_err_q <= parity_err_d;
`ifdef SWIPT_RX_PARITY_EN
      par_bit_q    <= par_bit_d;
`endif
    end
  end

  assign adc_address = ADC_ADDR;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_busy     = rx_busy_q;
  assign threshold   = thr_q;
  assign frame_err   = frame_err_q;
  assign overrun     = overrun_q;
  assign parity_err  = parity_err_q;

endmodule

// File: tb/tb_swipt_ask_receiver.sv
// Directed bench for swipt_ask_receiver with short bit times
// (BIT_CYCLES=64, AVG_LOG2=3, CAL_LOG2=4, HYST=100; '0'=1000, '1'=1400).
module tb_swipt_ask_receiver;

  localparam int BC = 64;
  localparam logic [11:0] LO = 12'd1000;
  localparam logic [11:0] HI = 12'd1400;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        enable = 1'b0;
  logic [11:0] adc = 12'd0;
  logic        rx_ready = 1'b0;
  logic [6:0]  adc_address;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_busy;
  logic [11:0] threshold;
  logic        frame_err;
  logic        overrun;
  logic        parity_err;

  int n_vec = 0;
  int n_err = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int pe_cnt = 0;

  swipt_ask_receiver #(
    .ADC_W      (12),
    .BIT_CYCLES (BC),
    .AVG_LOG2   (3),
    .CAL_LOG2   (4),
    .HYST       (12'd100),
    .ADC_ADDR   (7'h1E)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .enable      (enable),
    .ADC_in      (adc),
    .adc_address (adc_address),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_busy     (rx_busy),
    .threshold   (threshold),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  // Count cycles each pulse output is high.
  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (parity_err) pe_cnt++;
  end

  typedef struct {
    logic [7:0] data;
    logic       stop_hi;
    logic       ack;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_fe;
    int         exp_ov;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    adc = b ? HI : LO;
    cycles(BC);
  endtask

  // Full frame followed by idle; optionally pulse rx_ready on the stop decision edge.
  task automatic send_frame(input logic [7:0] d, input logic stop_hi,
                            input logic rdy_at_stop, input logic bad_par);
    send_bit(1'b1);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef SWIPT_RX_PARITY_EN
    send_bit((^d) ^ bad_par);
`else
    if (bad_par) $display("note: parity ignored in this build");
`endif
    adc = stop_hi ? HI : LO;
    if (rdy_at_stop) begin
      cycles(35);
      rx_ready = 1'b1;
      cycles(1);
      rx_ready = 1'b0;
      cycles(BC - 36);
    end else begin
      cycles(BC);
    end
    adc = LO;
    cycles(48);
  endtask

  task automatic ack_byte(input string name);
    rx_ready = 1'b1;
    cycles(1);
    rx_ready = 1'b0;
    check(name, {31'd0, rx_valid}, 32'd0);
  endtask

  initial begin
    int fe0, ov0;
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 0, 0};
    vecs[1] = '{8'h5A, 1'b1, 1'b0, 1'b0, 8'hA5, 1, 0};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 0, 0};
    vecs[3] = '{8'hC3, 1'b0, 1'b1, 1'b1, 8'h3C, 0, 1};
    vecs[4] = '{8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 0, 0};
    vecs[5] = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 0, 0};

    // Reset state
    cycles(3);
    check("rst_data", {24'd0, rx_data}, 32'd0);
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_thr", {20'd0, threshold}, 32'hFFF);
    check("rst_busy", {31'd0, rx_busy}, 32'd0);
    check("rst_pulses", {29'd0, frame_err, overrun, parity_err}, 32'd0);
    check("adc_addr", {25'd0, adc_address}, 32'h1E);

    // Calibration on a 1000 idle level
    nrst = 1'b1;
    enable = 1'b1;
    adc = LO;
    cycles(5);
    check("thr_during_cal", {20'd0, threshold}, 32'hFFF);
    cycles(15);
    check("thr_after_cal", {20'd0, threshold}, 32'd1100);
    check("busy_hunt", {31'd0, rx_busy}, 32'd0);
    cycles(10);

    // Frame table
    for (int v = 0; v < 6; v++) begin
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      send_frame(vecs[v].data, vecs[v].stop_hi, 1'b0, 1'b0);
      check($sformatf("v%0d_valid", v), {31'd0, rx_valid}, {31'd0, vecs[v].exp_valid});
      check($sformatf("v%0d_data", v), {24'd0, rx_data}, {24'd0, vecs[v].exp_data});
      check($sformatf("v%0d_ferr", v), fe_cnt - fe0, vecs[v].exp_fe);
      check($sformatf("v%0d_ovr", v), ov_cnt - ov0, vecs[v].exp_ov);
      if (vecs[v].ack) ack_byte($sformatf("v%0d_ack", v));
    end

    // Accept and new store on the same edge: no overrun, new byte kept
    send_frame(8'h11, 1'b0, 1'b0, 1'b0);
    check("b11_data", {24'd0, rx_data}, 32'h11);
    ov0 = ov_cnt;
    send_frame(8'h22, 1'b0, 1'b1, 1'b0);
    check("same_edge_valid", {31'd0, rx_valid}, 32'd1);
    check("same_edge_data", {24'd0, rx_data}, 32'h22);
    check("same_edge_ovr", ov_cnt - ov0, 32'd0);

    // Glitch: short high burst is rejected at the start decision
    fe0 = fe_cnt;
    adc = HI;
    cycles(5);
    check("glitch_busy", {31'd0, rx_busy}, 32'd1);
    cycles(5);
    adc = LO;
    cycles(50);
    check("glitch_idle", {31'd0, rx_busy}, 32'd0);
    check("glitch_ferr", fe_cnt - fe0, 32'd0);
    check("glitch_data", {24'd0, rx_data}, 32'h22);

    // Link drop during data bit 4, then re-calibration at a new idle level
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    adc = HI;
    cycles(10);
    check("drop_busy_before", {31'd0, rx_busy}, 32'd1);
    enable = 1'b0;
    adc = 12'd900;
    cycles(2);
    check("drop_busy", {31'd0, rx_busy}, 32'd0);
    check("drop_valid_kept", {31'd0, rx_valid}, 32'd1);
    check("drop_data_kept", {24'd0, rx_data}, 32'h22);
    enable = 1'b1;
    cycles(25);
    check("recal_thr", {20'd0, threshold}, 32'd1000);
    ack_byte("drop_ack");
    send_frame(8'h96, 1'b0, 1'b0, 1'b0);
    check("recal_data", {24'd0, rx_data}, 32'h96);
    check("recal_valid", {31'd0, rx_valid}, 32'd1);

`ifdef SWIPT_RX_PARITY_EN
    ack_byte("par_pre_ack");
    fe0 = pe_cnt;
    send_frame(8'h01, 1'b0, 1'b0, 1'b1);
    check("par_err", pe_cnt - fe0, 32'd1);
    check("par_drop", {31'd0, rx_valid}, 32'd0);
`else
    check("par_off", pe_cnt, 32'd0);
`endif

    // Reset in the middle of a frame discards everything
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    nrst = 1'b0;
    cycles(2);
    check("mid_rst_valid", {31'd0, rx_valid}, 32'd0);
    check("mid_rst_data", {24'd0, rx_data}, 32'd0);
    check("mid_rst_thr", {20'd0, threshold}, 32'hFFF);
    check("mid_rst_busy", {31'd0, rx_busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
